// File: rtl/program_counter_unit_pkg.sv
// Shared encodings and constants for the IF-stage program counter unit.
package program_counter_unit_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2
  } pc_state_e;

  // Next-PC source, listed in descending priority
  typedef enum logic [2:0] {
    SEL_EXC  = 3'd0,
    SEL_JR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_BR   = 3'd3,
    SEL_HOLD = 3'd4,
    SEL_SEQ  = 3'd5
  } pc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

  // Instruction addresses must be word aligned
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Any select other than hold/sequential changes control flow and squashes IF/ID
  function automatic logic sel_is_redirect(input pc_sel_e sel);
    return (sel == SEL_EXC) || (sel == SEL_JR) || (sel == SEL_J) || (sel == SEL_BR);
  endfunction

endpackage

// File: rtl/program_counter_unit_pc_next_select.sv
// Combinational next-PC priority encoder: picks the PC source and flags
// a misaligned redirect target.
module pc_next_select
  import program_counter_unit_pkg::*;
(
  input  logic        exception,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output pc_sel_e     sel,
  output logic [31:0] redirect_target,
  output logic        misaligned_fault
);

  // Priority: exception > jr > j > branch > stall > sequential
  always_comb begin
    sel             = SEL_SEQ;
    redirect_target = 32'h0;
    if (exception) begin
      sel = SEL_EXC;
    end else if (jump_reg) begin
      sel             = SEL_JR;
      redirect_target = reg_target;
    end else if (jump) begin
      sel             = SEL_J;
      redirect_target = jump_target;
    end else if (branch_taken) begin
      sel             = SEL_BR;
      redirect_target = branch_target;
    end else if (stall) begin
      sel = SEL_HOLD;
    end
  end

  // Only address-carrying redirects can fault; the exception vector is trusted
  assign misaligned_fault = ((sel == SEL_JR) || (sel == SEL_J) || (sel == SEL_BR))
                            && is_misaligned(redirect_target);

endmodule

// File: rtl/program_counter_unit.sv
// IF-stage architectural PC register with redirect arbitration, boot/redirect
// FSM, IF/ID flush pulse, EPC capture and fetch counter.
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResult,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget,
  input  logic        Exception,
  input  logic [31:0] ExcPC,
  output logic [31:0] PCResult,
  output logic        FetchValid,
  output logic        IFFlush,
  output logic [31:0] EPC,
  output logic        Misaligned,
  output logic [31:0] FetchCount
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        if_flush_q, if_flush_d;

  pc_sel_e     sel;
  logic [31:0] redirect_target;
  logic        misaligned_fault;
  logic        redirect;

  pc_next_select u_next_select (
    .exception        (Exception),
    .jump_reg         (JumpReg),
    .reg_target       (RegTarget),
    .jump             (Jump),
    .jump_target      (JumpTarget),
    .branch_taken     (BranchTaken),
    .branch_target    (BranchTarget),
    .stall            (Stall),
    .sel              (sel),
    .redirect_target  (redirect_target),
    .misaligned_fault (misaligned_fault)
  );

  assign redirect = sel_is_redirect(sel);

  // Next-state logic for the FSM, PC, EPC, sticky fault and fetch counter
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;
    fetch_valid_d = fetch_valid_q;
    if_flush_d    = 1'b0;
    case (state_q)
      S_BOOT: begin
        // Inputs are ignored while the boot cycle drains
        state_d       = S_RUN;
        fetch_valid_d = 1'b1;
      end
      S_RUN, S_REDIRECT: begin
        case (sel)
          SEL_EXC: begin
            pc_d  = EXC_VECTOR;
            epc_d = ExcPC;
          end
          SEL_JR, SEL_J, SEL_BR: begin
            if (misaligned_fault) begin
              pc_d         = EXC_VECTOR;
              epc_d        = redirect_target;
              misaligned_d = 1'b1;
            end else begin
              pc_d = redirect_target;
            end
          end
          SEL_HOLD: pc_d = pc_q;
          default:  pc_d = PCAddResult;
        endcase
        if (fetch_valid_q && (!Stall || redirect)) begin
          fetch_count_d = fetch_count_q + 32'd1;
        end
        if_flush_d    = redirect;
        fetch_valid_d = 1'b1;
        state_d       = redirect ? S_REDIRECT : S_RUN;
      end
      default: begin
        // Unused encoding: recover through the boot cycle
        state_d       = S_BOOT;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      epc_q         <= 32'h0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= 32'h0;
      fetch_valid_q <= 1'b0;
      if_flush_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
      fetch_valid_q <= fetch_valid_d;
      if_flush_q    <= if_flush_d;
    end
  end

  assign PCResult   = pc_q;
  assign FetchValid = fetch_valid_q;
  assign IFFlush    = if_flush_q;
  assign EPC        = epc_q;
  assign Misaligned = misaligned_q;
  assign FetchCount = fetch_count_q;

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
- Architectural PC register and next-PC selector for the IF stage of the 5-stage MIPS pipeline.
- Drives PCResult to the PC+4 adder and to instruction memory. Consumes the adder's PCAddResult as the sequential next PC.
- Arbitrates branch, jump and jump-register redirects, hazard-unit stalls and exceptions.
- Generates the IF/ID flush pulse, EPC capture and a fetch counter.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on Reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception or misaligned redirect.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PCAddResult  in  32  PCResult+4 from the adder.
- Stall  in  1  hazard-unit hold; freezes sequential advance.
- BranchTaken  in  1  branch resolved taken this cycle.
- BranchTarget  in  32  branch target address.
- Jump  in  1  j/jal redirect.
- JumpTarget  in  32  formed jump target.
- JumpReg  in  1  jr/jalr redirect.
- RegTarget  in  32  rs value for jr.
- Exception  in  1  exception request (e.g. overflow), one cycle.
- ExcPC  in  32  PC of the faulting instruction.
- PCResult  out  32  current PC.
- FetchValid  out  1  PCResult is a valid fetch address this cycle.
- IFFlush  out  1  squash the IF/ID register contents.
- EPC  out  32  exception PC.
- Misaligned  out  1  sticky flag for misaligned-redirect fault.
- FetchCount  out  32  number of fetches accepted.

Behaviour:
- Reset (async, any state, mid-operation included):
  - PCResult=RESET_VECTOR, EPC=0, Misaligned=0, FetchCount=0, IFFlush=0, FetchValid=0.
  - State=S_BOOT.
- FSM states: S_BOOT, S_RUN, S_REDIRECT.
  - S_BOOT: one cycle after Reset deasserts. PC holds and FetchValid=0. Next state is S_RUN.
  - S_RUN: FetchValid=1. Next PC is selected by priority (below).
  - S_REDIRECT: entered for exactly one cycle after any redirect is taken. IFFlush=1 and FetchValid=1 (the new target is fetched). Next-PC selection is identical to S_RUN, so back-to-back redirects stay in S_REDIRECT.
- Next-PC priority, evaluated at every rising edge in S_RUN/S_REDIRECT:
  1. Exception: PC<=EXC_VECTOR, EPC<=ExcPC.
  2. JumpReg: PC<=RegTarget.
  3. Jump: PC<=JumpTarget.
  4. BranchTaken: PC<=BranchTarget.
  5. Stall: PC holds.
  6. Otherwise: PC<=PCAddResult.
- Stall handling:
  - Redirects (1-4) override Stall. The hazard unit must qualify redirect inputs.
  - Stall alone never asserts IFFlush.
- Misaligned redirect (applies to 2-4 when the target has bits[1:0]!=0):
  - Handled as an exception: PC<=EXC_VECTOR, EPC<=offending target, Misaligned<=1.
  - Misaligned stays set until Reset.
- Inputs are ignored in S_BOOT.
- PCAddResult is used unmodified. Wrap-around from 32'hFFFF_FFFC to 0 is legal and is not a fault.
- IFFlush is registered: high in the cycle after the redirect edge, low otherwise.
- FetchCount increments by 1 at each edge where FetchValid=1 and (Stall=0 or a redirect is taken). It wraps modulo 2^32.
- Latency: a redirect request at edge N is visible on PCResult after edge N, with IFFlush high during cycle N+1.

Decomposition:
- Shared package holds:
  - the state encoding (S_BOOT=2'd0, S_RUN=2'd1, S_REDIRECT=2'd2);
  - the vector constants;
  - a 3-bit next-PC select encoding (SEL_EXC, SEL_JR, SEL_J, SEL_BR, SEL_HOLD, SEL_SEQ).
- One natural sub-module: pc_next_select. It is the combinational priority encoder that produces the select code and the misaligned-fault indication. The register, FSM and counter stay in the top module.

Test Plan:
- Reset, release, run 3 cycles with no redirects and PCAddResult=PC+4 -> FetchValid=0 in the boot cycle, then PCResult 0x0, 0x4, 0x8; FetchCount=2.
- At PC=0x10, Stall=1 for 2 cycles -> PCResult holds 0x10, FetchCount frozen, IFFlush=0; after release PCResult=0x14.
- BranchTaken=1 with BranchTarget=0x40 while Stall=1 -> next PCResult=0x40, IFFlush=1 for exactly one cycle.
- Exception, JumpReg(0x100) and Jump(0x200) all asserted together, ExcPC=0x24 -> PCResult=0x80000180, EPC=0x24.
- JumpReg with RegTarget=0x102 -> PCResult=0x80000180, EPC=0x102, Misaligned=1 (still set after 10 cycles).
- Assert Reset asynchronously mid-redirect at PC=0x40 -> PCResult=0x0 immediately, IFFlush=0, FetchCount=0, Misaligned=0.
